// File: rtl/fmc150_spi_core.sv
// SPI master for one FMC150 serial target (CDCE72010 or DAC3283), 32-bit MSB-first frames.
// Optional readback path (two-frame reads, capture register, rsp_*) is built when FMC_SPI_READBACK_EN is defined.
module fmc150_spi_core #(
  parameter int CLK_DIV     = 4,
  parameter int CS_IDLE     = 8,
  parameter int SRST_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  input  logic        cmd_read,
  input  logic        srst_req,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        sclkn,
  output logic        sclkgate,
  output logic        sdo,
  output logic        csb,
  input  logic        sdi,
  output logic        srst
);

  // state | meaning
  // RST   | target reset pulse, srst held low
  // IDLE  | waiting for a command or reset request
  // SETUP | csb low, first bit on sdo, pin clock low
  // SHIFT | 32 gated pin-clock periods
  // HOLD  | csb low after last bit
  // GAP   | csb high between frames
  localparam logic [2:0] ST_RST   = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_SETUP = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;

  localparam int M1   = (SRST_CYCLES > CS_IDLE) ? SRST_CYCLES : CS_IDLE;
  localparam int TMAX = (M1 > CLK_DIV) ? M1 : CLK_DIV;
  localparam int TW   = $clog2(TMAX + 1);

  logic [2:0]    state;
  logic [TW-1:0] tmr;
  logic [4:0]    bit_cnt;
  logic          half;
  logic [31:0]   shreg;
  logic          is_read;
  logic          second;
  logic          srst_pend;
  logic          rd_in;
  logic          tmr_done;
  logic          last_frame;
  logic          req_now;

  assign tmr_done   = (tmr == '0);
  assign last_frame = !(is_read && !second);
  assign req_now    = srst_pend | srst_req;
  assign cmd_ready  = (state == ST_IDLE) && !srst_pend && !srst_req;

`ifdef FMC_SPI_READBACK_EN
  assign rd_in = cmd_read;
`else
  assign rd_in = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_RST;
      tmr       <= TW'(SRST_CYCLES - 1);
      bit_cnt   <= '0;
      half      <= 1'b0;
      shreg     <= '0;
      is_read   <= 1'b0;
      second    <= 1'b0;
      srst_pend <= 1'b0;
      csb       <= 1'b1;
      sclkn     <= 1'b1;
      sclkgate  <= 1'b0;
      sdo       <= 1'b0;
      srst      <= 1'b0;
    end else begin
      // requests arriving mid-transaction are held until the final gap ends
      if (srst_req && state != ST_IDLE && state != ST_RST)
        srst_pend <= 1'b1;

      case (state)
        ST_RST: begin
          if (tmr_done) begin
            srst  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end

        ST_IDLE: begin
          if (srst_req) begin
            state <= ST_RST;
            srst  <= 1'b0;
            tmr   <= TW'(SRST_CYCLES - 1);
          end else if (cmd_valid) begin
            shreg   <= cmd_data;
            sdo     <= cmd_data[31];
            is_read <= rd_in;
            second  <= 1'b0;
            csb     <= 1'b0;
            tmr     <= TW'(CLK_DIV - 1);
            state   <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (tmr_done) begin
            state    <= ST_SHIFT;
            tmr      <= TW'(CLK_DIV - 1);
            bit_cnt  <= 5'd31;
            half     <= 1'b0;
            sclkn    <= 1'b0;
            sclkgate <= 1'b1;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end

        ST_SHIFT: begin
          if (!tmr_done) begin
            tmr <= tmr - TW'(1);
          end else begin
            tmr <= TW'(CLK_DIV - 1);
            if (!half) begin
              half  <= 1'b1;
              sclkn <= 1'b1;
            end else begin
              half <= 1'b0;
              if (bit_cnt == 5'd0) begin
                state    <= ST_HOLD;
                sclkn    <= 1'b1;
                sclkgate <= 1'b0;
                sdo      <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt - 5'd1;
                shreg   <= {shreg[30:0], 1'b0};
                sdo     <= shreg[30];
                sclkn   <= 1'b0;
              end
            end
          end
        end

        ST_HOLD: begin
          if (tmr_done) begin
            csb <= 1'b1;
            // the IDLE accept cycle counts as the last csb-high cycle before a new command
            if (!last_frame) begin
              state <= ST_GAP;
              tmr   <= TW'(CS_IDLE - 1);
            end else if (CS_IDLE > 1) begin
              state <= ST_GAP;
              tmr   <= TW'(CS_IDLE - 2);
            end else if (req_now) begin
              state     <= ST_RST;
              srst      <= 1'b0;
              srst_pend <= 1'b0;
              tmr       <= TW'(SRST_CYCLES - 1);
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            tmr <= tmr - TW'(1);
          end
        end

        ST_GAP: begin
          if (tmr_done) begin
            if (!last_frame) begin
              second <= 1'b1;
              shreg  <= '0;
              sdo    <= 1'b0;
              csb    <= 1'b0;
              tmr    <= TW'(CLK_DIV - 1);
              state  <= ST_SETUP;
            end else if (req_now) begin
              state     <= ST_RST;
              srst      <= 1'b0;
              srst_pend <= 1'b0;
              tmr       <= TW'(SRST_CYCLES - 1);
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            tmr <= tmr - TW'(1);
          end
        end

        default: begin
          state <= ST_RST;
          srst  <= 1'b0;
          csb   <= 1'b1;
          tmr   <= TW'(SRST_CYCLES - 1);
        end
      endcase
    end
  end

`ifdef FMC_SPI_READBACK_EN
  logic [31:0] cap;

  // sdi is taken on the same edge that raises the pin clock
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cap       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == ST_SHIFT && tmr_done && !half)
        cap <= {cap[30:0], sdi};
      if (state == ST_HOLD && tmr_done && is_read && second) begin
        rsp_data  <= cap;
        rsp_valid <= 1'b1;
      end
    end
  end
`else
  logic unused_rd;
  assign unused_rd = cmd_read ^ sdi;
  assign rsp_valid = 1'b0;
  assign rsp_data  = '0;
`endif

endmodule

// File: tb/tb_fmc150_spi_core.sv
// Scoreboard bench for fmc150_spi_core: stimulus queues expected frames/responses, monitor checks them.
module tb_fmc150_spi_core;
  localparam int CLK_DIV     = 4;
  localparam int CS_IDLE     = 8;
  localparam int SRST_CYCLES = 64;
  localparam int FRAME_LEN   = 66 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n, cmd_valid, cmd_read, srst_req, sdi;
  logic [31:0] cmd_data;
  logic        cmd_ready, rsp_valid, sclkn, sclkgate, sdo, csb, srst;
  logic [31:0] rsp_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_frames[$];
  logic [31:0] exp_rsp[$];
  logic [31:0] tgt_word = 32'h1234_5678;
  int last_gap = 0;

  // monitor state
  logic        m_pin_q, m_csb_q, m_rv_q;
  logic [31:0] m_sh;
  int          m_rises, m_low, m_high;
  // target model state
  logic        t_pin_q, t_csb_q;
  int          t_bit;

  fmc150_spi_core #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE), .SRST_CYCLES(SRST_CYCLES)) dut (
    .CLK(clk), .RST_N(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_read(cmd_read), .srst_req(srst_req),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .sclkn(sclkn), .sclkgate(sclkgate),
    .sdo(sdo), .csb(csb), .sdi(sdi), .srst(srst)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected event, expected none", name);
  endfunction

  // scoreboard monitor: frames are checked at each csb rise, responses on rsp_valid
  initial begin
    m_pin_q = 1'b0; m_csb_q = 1'b1; m_rv_q = 1'b0;
    m_sh = '0; m_rises = 0; m_low = 0; m_high = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        m_pin_q = 1'b0; m_csb_q = 1'b1; m_rv_q = 1'b0;
        m_rises = 0; m_low = 0; m_high = 0;
      end else begin
        if (!csb) begin
          if (m_csb_q) begin
            last_gap = m_high;
            m_rises = 0; m_low = 0; m_sh = '0;
          end
          m_low++;
          if ((sclkn & sclkgate) && !m_pin_q) begin
            m_rises++;
            m_sh = {m_sh[30:0], sdo};
          end
        end else begin
          if (!m_csb_q) begin
            if (exp_frames.size() == 0) fail_now("unexpected_frame");
            else begin
              chk("frame_data", m_sh, exp_frames.pop_front());
              chk("frame_rises", m_rises, 32);
              chk("frame_len", m_low, FRAME_LEN);
            end
            m_high = 0;
          end
          m_high++;
        end
        if (rsp_valid) begin
          if (m_rv_q) fail_now("rsp_valid_width");
          if (exp_rsp.size() == 0) fail_now("unexpected_rsp");
          else chk("rsp_data", rsp_data, exp_rsp.pop_front());
        end
        m_pin_q = sclkn & sclkgate;
        m_csb_q = csb;
        m_rv_q  = rsp_valid;
      end
    end
  end

  // target model: drives sdi MSB first, advances on pin-clock falls
  initial begin
    sdi = 1'b0; t_pin_q = 1'b0; t_csb_q = 1'b1; t_bit = 31;
    forever begin
      @(posedge clk); #1;
      if (!csb && t_csb_q) begin
        t_bit = 31;
        sdi = tgt_word[t_bit];
      end else if (!csb && t_pin_q && !(sclkn & sclkgate) && t_bit > 0) begin
        t_bit--;
        sdi = tgt_word[t_bit];
      end
      t_pin_q = sclkn & sclkgate;
      t_csb_q = csb;
    end
  end

  task automatic send(input logic [31:0] w, input logic rd);
    int n = 0;
    @(negedge clk);
    cmd_data = w; cmd_read = rd; cmd_valid = 1'b1;
    while (!cmd_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      fail_now("send_timeout");
      cmd_valid = 1'b0;
      return;
    end
    exp_frames.push_back(w);
`ifdef FMC_SPI_READBACK_EN
    if (rd) begin
      exp_frames.push_back(32'h0);
      exp_rsp.push_back(tgt_word);
    end
`endif
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(cmd_ready && exp_frames.size() == 0 && exp_rsp.size() == 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) fail_now("wait_idle_timeout");
  endtask

  task automatic srst_check(string name, input bit chk_ready);
    int n = 0;
    logic ready_seen = 1'b0;
    while (srst && n < 3000) begin
      if (cmd_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (srst) begin
      fail_now({name, "_fall_timeout"});
      return;
    end
    chk({name, "_csb_at_fall"}, csb, 1'b1);
    n = 0;
    while (!srst && n < 1000) begin
      if (cmd_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk(name, n, SRST_CYCLES);
    if (chk_ready) chk({name, "_ready"}, ready_seen, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic low_seen;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; cmd_read = 1'b0; srst_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_csb", csb, 1'b1);
    chk("reset_sclkn", sclkn, 1'b1);
    chk("reset_sclkgate", sclkgate, 1'b0);
    chk("reset_srst", srst, 1'b0);
    chk("reset_sdo", sdo, 1'b0);
    chk("reset_ready", cmd_ready, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_data", rsp_data, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!srst && n < 1000);
    chk("srst_release_len", n, SRST_CYCLES);
    chk("ready_after_reset", cmd_ready, 1'b1);

    send(32'hA5F0_0C31, 1'b0);
    wait_idle();

    send(32'h0000_000E, 1'b1);
    wait_idle();

    send(32'h0F0F_1234, 1'b0);
    send(32'hFFFF_0001, 1'b0);
    wait_idle();
    chk("b2b_gap", last_gap, CS_IDLE);
`ifdef FMC_SPI_READBACK_EN
    chk("rsp_hold", rsp_data, 32'h1234_5678);
`endif

    // reset request mid-frame, repeated to exercise coalescing
    send(32'h8000_0001, 1'b0);
    repeat (100) @(posedge clk);
    @(negedge clk); srst_req = 1'b1;
    @(negedge clk); srst_req = 1'b0;
    repeat (30) @(negedge clk);
    srst_req = 1'b1;
    @(negedge clk); srst_req = 1'b0;
    srst_check("srst_midframe_len", 1'b1);
    chk("srst_midframe_frames_left", exp_frames.size(), 0);
    low_seen = 1'b0;
    repeat (200) begin
      @(posedge clk); #1;
      if (!srst) low_seen = 1'b1;
    end
    chk("srst_single_pulse", low_seen, 1'b0);

    // reset request colliding with a command offer in IDLE
    wait_idle();
    @(negedge clk);
    cmd_data = 32'hDEAD_BEEF; cmd_read = 1'b0; cmd_valid = 1'b1; srst_req = 1'b1;
    #1;
    chk("ready_vs_srst", cmd_ready, 1'b0);
    @(posedge clk); #1;
    srst_req = 1'b0; cmd_valid = 1'b0;
    srst_check("srst_idle_len", 1'b0);

    // RST_N during SHIFT aborts the transaction
    wait_idle();
    send(32'hC3C3_3C3C, 1'b1);
    n = 0;
    while (!sclkgate && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!sclkgate) fail_now("abort_shift_timeout");
    repeat (20) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_csb", csb, 1'b1);
    chk("abort_sclkgate", sclkgate, 1'b0);
    exp_frames.delete();
    exp_rsp.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!srst && n < 1000);
    chk("srst_after_abort", n, SRST_CYCLES);

    send(32'h5A5A_0001, 1'b0);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
